// File: rtl/food_gen_if.sv
// Meal-request and food-placement bus between snake (master) and food_gen (slave).
interface food_gen_if;
  localparam int unsigned CoordW = 5;
  localparam int unsigned BodyW  = 320;
  localparam int unsigned LenW   = 6;

  logic [1:0]        game_state;
  logic              get_food;
  logic [BodyW-1:0]  snake_x_1dim;
  logic [BodyW-1:0]  snake_y_1dim;
  logic [LenW-1:0]   snake_length;
  logic [CoordW-1:0] food_x;
  logic [CoordW-1:0] food_y;
  logic              food_valid;
  logic              busy;

  modport master (
    output game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
    input  food_x, food_y, food_valid, busy
  );

  modport slave (
    input  game_state, get_food, snake_x_1dim, snake_y_1dim, snake_length,
    output food_x, food_y, food_valid, busy
  );
endinterface

// File: rtl/food_gen.sv
// Pseudo-random food placement for snake on a 32x24 grid.
// Define FOOD_AVOID_SNAKE_EN to scan the body and relocate food off the snake.
module food_gen #(
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter logic [4:0]  INIT_X = 5'd20,
  parameter logic [4:0]  INIT_Y = 5'd9
) (
  input logic       clk,
  input logic       rst_n,
  food_gen_if.slave food_if
);
  localparam int unsigned LfsrW  = 16;
  localparam int unsigned CoordW = 5;
  localparam int unsigned GridH  = 24;

  localparam logic [1:0] GsRunning = 2'b00;
  localparam logic [1:0] GsDie     = 2'b01;
  localparam logic [1:0] GsInitial = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PICK   = 2'd1,
    SCAN   = 2'd2,
    COMMIT = 2'd3
  } state_e;

  state_e            state_q;
  logic [LfsrW-1:0]  lfsr_q;
  logic [LfsrW-1:0]  lfsr_d;
  logic              get_food_dly_q;
  logic [CoordW-1:0] cand_x_q;
  logic [CoordW-1:0] cand_y_q;
  logic [CoordW-1:0] food_x_q;
  logic [CoordW-1:0] food_y_q;
  logic              food_valid_q;
  logic              busy_q;
  logic              start_c;
  logic [CoordW-1:0] pick_y_c;

  assign lfsr_d   = {lfsr_q[LfsrW-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign start_c  = food_if.get_food & ~get_food_dly_q &
                    (food_if.game_state == GsRunning) & (state_q == IDLE);
  // Rows 24..31 fold back onto 16..23 so every draw lands on the grid.
  assign pick_y_c = (lfsr_q[9:5] >= CoordW'(GridH)) ? CoordW'(lfsr_q[9:5] - CoordW'(8))
                                                     : lfsr_q[9:5];

`ifdef FOOD_AVOID_SNAKE_EN
  localparam int unsigned IdxW = 6;

  logic [IdxW-1:0]   idx_q;
  logic [8:0]        seg_base_c;
  logic [CoordW-1:0] seg_x_c;
  logic [CoordW-1:0] seg_y_c;
  logic [CoordW-1:0] step_x_c;
  logic [CoordW-1:0] step_y_c;
  logic              hit_c;
  logic              last_c;

  assign seg_base_c = 9'(idx_q) * 9'd5;
  assign seg_x_c    = food_if.snake_x_1dim[seg_base_c +: CoordW];
  assign seg_y_c    = food_if.snake_y_1dim[seg_base_c +: CoordW];
  assign hit_c      = (seg_x_c == cand_x_q) && (seg_y_c == cand_y_q);
  assign last_c     = (idx_q == IdxW'(food_if.snake_length - IdxW'(1)));
  // Linear relocation: next column, carrying into the next row, wrapping at grid end.
  assign step_x_c   = CoordW'(cand_x_q + CoordW'(1));
  assign step_y_c   = (cand_x_q != CoordW'(31)) ? cand_y_q :
                      (cand_y_q == CoordW'(GridH - 1)) ? '0 : CoordW'(cand_y_q + CoordW'(1));
`else
  logic unused_body_c;
  assign unused_body_c = ^{food_if.snake_x_1dim, food_if.snake_y_1dim, food_if.snake_length};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lfsr_q         <= SEED;
      get_food_dly_q <= 1'b0;
      cand_x_q       <= '0;
      cand_y_q       <= '0;
      food_x_q       <= INIT_X;
      food_y_q       <= INIT_Y;
      food_valid_q   <= 1'b1;
      busy_q         <= 1'b0;
`ifdef FOOD_AVOID_SNAKE_EN
      idx_q          <= '0;
`endif
    end else begin
      lfsr_q <= lfsr_d;
      if (food_if.game_state == GsInitial) begin
        state_q        <= IDLE;
        get_food_dly_q <= food_if.get_food;
        food_x_q       <= INIT_X;
        food_y_q       <= INIT_Y;
        food_valid_q   <= 1'b1;
        busy_q         <= 1'b0;
      end else if (food_if.game_state != GsDie) begin
        get_food_dly_q <= food_if.get_food;
        case (state_q)
          IDLE: begin
            if (start_c) begin
              state_q      <= PICK;
              food_valid_q <= 1'b0;
              busy_q       <= 1'b1;
            end
          end
          PICK: begin
            cand_x_q <= lfsr_q[4:0];
            cand_y_q <= pick_y_c;
`ifdef FOOD_AVOID_SNAKE_EN
            idx_q    <= '0;
            state_q  <= (food_if.snake_length == '0) ? COMMIT : SCAN;
`else
            state_q  <= COMMIT;
`endif
          end
`ifdef FOOD_AVOID_SNAKE_EN
          SCAN: begin
            if (hit_c) begin
              cand_x_q <= step_x_c;
              cand_y_q <= step_y_c;
              idx_q    <= '0;
            end else if (last_c) begin
              state_q <= COMMIT;
            end else begin
              idx_q <= IdxW'(idx_q + IdxW'(1));
            end
          end
`endif
          COMMIT: begin
            food_x_q     <= cand_x_q;
            food_y_q     <= cand_y_q;
            food_valid_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign food_if.food_x     = food_x_q;
  assign food_if.food_y     = food_y_q;
  assign food_if.food_valid = food_valid_q;
  assign food_if.busy       = busy_q;
endmodule
